// File: rtl/fence_seq_ctrl.sv
// Fence sequencer: drains the store buffer, then issues D$/I$/TLB flushes
// and a pipeline flush for FENCE, FENCE_I and SFENCE_VMA requests.
`timescale 1ns/1ps
module fence_seq_ctrl #(
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    input  logic [1:0]       req_type_i,
    output logic             req_ready_o,
    input  logic             halt_i,
    input  logic             no_st_pending_i,
    output logic             dcache_flush_o,
    input  logic             dcache_flush_ack_i,
    output logic             icache_flush_o,
    output logic             tlb_flush_o,
    output logic             flush_pipeline_o,
    output logic             done_o,
    output logic             err_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] seq_cnt_o
);

    localparam int DCNT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DRAIN_TIMEOUT);
    localparam logic [DCNT_W-1:0] DCNT_TMO = DCNT_W'(DRAIN_TIMEOUT - 1);

    localparam logic [1:0] T_FENCE_I = 2'b01;
    localparam logic [1:0] T_SFENCE  = 2'b10;
    localparam logic [1:0] T_RSVD    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH_D,
        S_FLUSH_I,
        S_FLUSH_TLB,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        type_q, type_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0]  seq_cnt_q, seq_cnt_d;
    logic              accept;

    assign req_ready_o = (state_q == S_IDLE) && !halt_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        dcnt_d    = dcnt_q;
        seq_cnt_d = seq_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    type_d  = req_type_i;
                    dcnt_d  = '0;
                    state_d = (req_type_i == T_RSVD) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Saturating, so the timeout compare value is crossed only once.
                if (dcnt_q != DCNT_MAX) begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
                if (no_st_pending_i) begin
                    state_d = (type_q == T_SFENCE) ? S_FLUSH_TLB : S_FLUSH_D;
                end
            end
            S_FLUSH_D: begin
                if (dcache_flush_ack_i) begin
                    state_d = (type_q == T_FENCE_I) ? S_FLUSH_I : S_DONE;
                end
            end
            S_FLUSH_I:   state_d = S_DONE;
            S_FLUSH_TLB: state_d = S_DONE;
            S_DONE: begin
                seq_cnt_d = seq_cnt_q + CNT_W'(1);
                state_d   = S_IDLE;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            type_q    <= 2'b00;
            dcnt_q    <= '0;
            seq_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            dcnt_q    <= dcnt_d;
            seq_cnt_q <= seq_cnt_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign dcache_flush_o   = (state_q == S_FLUSH_D);
    assign icache_flush_o   = (state_q == S_FLUSH_I);
    assign tlb_flush_o      = (state_q == S_FLUSH_TLB);
    assign done_o           = (state_q == S_DONE);
    assign flush_pipeline_o = (state_q == S_DONE);
    assign err_o            = (state_q == S_DONE) && (type_q == T_RSVD);
    assign timeout_o        = (state_q == S_DRAIN) && (dcnt_q == DCNT_TMO) && !no_st_pending_i;
    assign seq_cnt_o        = seq_cnt_q;

endmodule

// File: tb/tb_fence_seq_ctrl.sv
// Scoreboard bench for fence_seq_ctrl: the driver pushes the expected outcome
// of each request, the monitor pops and compares it when done_o fires.
`timescale 1ns/1ps
module tb_fence_seq_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic [1:0]    req_type_i = 2'b00;
    logic          req_ready_o;
    logic          halt_i = 1'b0;
    logic          no_st_pending_i = 1'b0;
    logic          dcache_flush_o;
    logic          dcache_flush_ack_i = 1'b0;
    logic          icache_flush_o;
    logic          tlb_flush_o;
    logic          flush_pipeline_o;
    logic          done_o;
    logic          err_o;
    logic          timeout_o;
    logic [CW-1:0] seq_cnt_o;

    fence_seq_ctrl #(.DRAIN_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid_i),
        .req_type_i         (req_type_i),
        .req_ready_o        (req_ready_o),
        .halt_i             (halt_i),
        .no_st_pending_i    (no_st_pending_i),
        .dcache_flush_o     (dcache_flush_o),
        .dcache_flush_ack_i (dcache_flush_ack_i),
        .icache_flush_o     (icache_flush_o),
        .tlb_flush_o        (tlb_flush_o),
        .flush_pipeline_o   (flush_pipeline_o),
        .done_o             (done_o),
        .err_o              (err_o),
        .timeout_o          (timeout_o),
        .seq_cnt_o          (seq_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] typ;
        int lat;
        int dcyc;
        int icyc;
        int tcyc;
        int tocnt;
        int tocyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor state
    int   cyc = 0;
    bit   in_seq = 0;
    bit   cnt_pend = 0;
    int   acc_cyc, m_d, m_i, m_t, m_to, m_tocyc, m_p;
    int   exp_cnt = 0;
    exp_t mon_e;

    initial begin : monitor
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_ni) begin
                in_seq   = 0;
                cnt_pend = 0;
                exp_cnt  = 0;
            end else begin
                if (cnt_pend) begin
                    chk("seq_cnt", int'(seq_cnt_o), exp_cnt);
                    cnt_pend = 0;
                end
                if (in_seq) begin
                    if (dcache_flush_o)   m_d++;
                    if (icache_flush_o)   m_i++;
                    if (tlb_flush_o)      m_t++;
                    if (flush_pipeline_o) m_p++;
                    if (timeout_o) begin
                        m_to++;
                        m_tocyc = cyc - acc_cyc;
                    end
                    if (done_o) begin
                        if (sb_q.size() == 0) begin
                            chk("done_unexpected", 1, 0);
                        end else begin
                            mon_e = sb_q.pop_front();
                            chk("latency", cyc - acc_cyc, mon_e.lat);
                            chk("err", int'(err_o), (mon_e.typ == 2'b11) ? 1 : 0);
                            chk("dflush_cycles", m_d, mon_e.dcyc);
                            chk("iflush_cycles", m_i, mon_e.icyc);
                            chk("tlb_cycles", m_t, mon_e.tcyc);
                            chk("pipe_flush_cycles", m_p, 1);
                            chk("timeout_pulses", m_to, mon_e.tocnt);
                            if (mon_e.tocnt > 0) chk("timeout_cycle", m_tocyc, mon_e.tocyc);
                            exp_cnt  = (exp_cnt + 1) % (1 << CW);
                            cnt_pend = 1;
                        end
                        in_seq = 0;
                    end
                end else begin
                    chk("idle_outputs", {dcache_flush_o, icache_flush_o, tlb_flush_o, done_o,
                                         flush_pipeline_o, err_o, timeout_o}, 0);
                    if (req_valid_i && req_ready_o) begin
                        in_seq  = 1;
                        acc_cyc = cyc;
                        m_d = 0; m_i = 0; m_t = 0; m_to = 0; m_tocyc = 0; m_p = 0;
                    end
                end
            end
        end
    end

    // Called at posedge+1. dwait: DRAIN cycles with stores pending; await_n:
    // FLUSH_D cycles before ack; hold: halted cycles before acceptance.
    task automatic run_seq(input logic [1:0] typ, input int dwait, input int await_n,
                           input int hold, input bit early_ack, input bit halt_seq);
        exp_t e;
        int   waited;
        bit   rdy;
        int   aw;
        aw      = early_ack ? 0 : await_n;
        e.typ   = typ;
        e.dcyc  = 0;
        e.icyc  = 0;
        e.tcyc  = 0;
        e.tocnt = 0;
        e.tocyc = 0;
        case (typ)
            2'b11: e.lat = 1;
            2'b10: begin e.lat = dwait + 3; e.tcyc = 1; end
            2'b01: begin e.lat = dwait + aw + 4; e.dcyc = aw + 1; e.icyc = 1; end
            default: begin e.lat = dwait + aw + 3; e.dcyc = aw + 1; end
        endcase
        if (typ != 2'b11 && dwait >= TMO) begin
            e.tocnt = 1;
            e.tocyc = TMO;
        end
        sb_q.push_back(e);

        req_valid_i        = 1'b1;
        req_type_i         = typ;
        no_st_pending_i    = 1'b0;
        dcache_flush_ack_i = early_ack;
        waited = 0;
        rdy    = 0;
        while (!rdy && waited < hold + 20) begin
            halt_i = (waited < hold);
            @(negedge clk_i);
            rdy = req_ready_o;
            if (waited < hold) chk("halt_ready", int'(rdy), 0);
            @(posedge clk_i);
            #1;
            waited++;
        end
        req_valid_i = 1'b0;
        halt_i      = 1'b0;
        if (!rdy) begin
            chk("accept_timeout", 0, 1);
        end else begin
            chk("accept_wait", waited, hold + 1);
            for (int c = 1; c <= e.lat; c++) begin
                halt_i             = halt_seq;
                no_st_pending_i    = (c > dwait);
                dcache_flush_ack_i = early_ack || (c >= dwait + 2 + aw);
                @(posedge clk_i);
                #1;
            end
        end
        dcache_flush_ack_i = 1'b0;
        halt_i             = 1'b0;
    endtask

    initial begin : driver
        int w;
        #12;
        chk("rst_outputs", {dcache_flush_o, icache_flush_o, tlb_flush_o, done_o,
                            flush_pipeline_o, err_o, timeout_o}, 0);
        chk("rst_ready", int'(req_ready_o), 1);
        chk("rst_seq_cnt", int'(seq_cnt_o), 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        run_seq(2'b01, 0, 2, 0, 0, 0);  // FENCE_I, ack 2 cycles after flush rises
        run_seq(2'b10, 5, 0, 0, 1, 0);  // SFENCE_VMA with drain timeout, early ack ignored
        run_seq(2'b11, 0, 0, 0, 0, 0);  // reserved type
        run_seq(2'b00, 0, 0, 4, 0, 0);  // halted for 4 cycles, then FENCE
        run_seq(2'b00, 2, 1, 0, 0, 1);  // FENCE with halt raised mid-sequence
        run_seq(2'b01, 0, 0, 0, 1, 0);  // FENCE_I minimum latency
        run_seq(2'b10, 0, 0, 0, 0, 0);  // SFENCE_VMA minimum latency
        run_seq(2'b00, 7, 0, 0, 0, 0);  // drain counter saturates past timeout

        // Reset while in FLUSH_D aborts the sequence.
        req_valid_i        = 1'b1;
        req_type_i         = 2'b00;
        no_st_pending_i    = 1'b1;
        dcache_flush_ack_i = 1'b0;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        w = 0;
        while (!dcache_flush_o && w < 10) begin
            @(negedge clk_i);
            w++;
        end
        chk("abort_dflush_high", int'(dcache_flush_o), 1);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("abort_dflush_async", int'(dcache_flush_o), 0);
        chk("abort_done", int'(done_o), 0);
        chk("abort_ready", int'(req_ready_o), 1);
        repeat (2) @(negedge clk_i);
        #2;
        rst_ni             = 1'b1;
        dcache_flush_ack_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        chk("abort_seq_cnt", int'(seq_cnt_o), 0);
        dcache_flush_ack_i = 1'b0;

        for (int k = 0; k < 5; k++) run_seq(2'b00, 0, 0, 0, 1, 0);
        @(negedge clk_i);
        chk("cnt_wrap_after_5", int'(seq_cnt_o), 1);

        w = 0;
        while (sb_q.size() != 0 && w < 20) begin
            @(negedge clk_i);
            w++;
        end
        chk("scoreboard_empty", sb_q.size(), 0);
        repeat (2) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
